// File: rtl/tick_timer_if.sv
// Control/status bundle between game logic and a tick_timer instance.
// The master drives the controls; the slave (the timer) drives the status.
interface tick_timer_if #(
   parameter int WIDTH = 16
);
   // Controls are sampled on the rising clk edge. start and stop are one-cycle
   // pulses, pause and auto_reload are levels, and no handshake is involved.
   logic             tick_in;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             pause;
   logic             auto_reload;
   logic             busy;
   logic [WIDTH-1:0] remaining;
   logic             expired;
   logic             tick_fault;

   modport master (
      output tick_in, load_val, start, stop, pause, auto_reload,
      input  busy, remaining, expired, tick_fault
   );

   modport slave (
      input  tick_in, load_val, start, stop, pause, auto_reload,
      output busy, remaining, expired, tick_fault
   );
endinterface

// File: rtl/tick_timer.sv
// Countdown timer clocked by game-time tick strobes, with pause and auto-reload.
// Define TICK_TIMEOUT_EN to add a sticky missing-tick detector (tick_fault).
module tick_timer #(
   parameter int WIDTH    = 16,
   parameter int TICK_GAP = 5000
) (
   input  logic         clk,
   input  logic         reset,
   tick_timer_if.slave  bus,
   output logic [1:0]   dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   state_e           state_q;
   logic             busy_q;
   logic             expired_q;
   logic             ar_q;
   logic [WIDTH-1:0] remaining_q;
   logic [WIDTH-1:0] reload_q;

   // stop beats start beats tick; any tick that arrives alongside a control is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         expired_q   <= 1'b0;
         ar_q        <= 1'b0;
         remaining_q <= '0;
         reload_q    <= '0;
      end else begin
         expired_q <= 1'b0;
         if (bus.stop) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            remaining_q <= '0;
         end else if (bus.start) begin
            if (bus.load_val != '0) begin
               state_q     <= RUN;
               busy_q      <= 1'b1;
               remaining_q <= bus.load_val;
               reload_q    <= bus.load_val;
               ar_q        <= bus.auto_reload;
            end else begin
               // A zero interval expires at once and never enters RUN.
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               remaining_q <= '0;
               expired_q   <= 1'b1;
            end
         end else begin
            case (state_q)
               RUN: begin
                  if (bus.pause) begin
                     state_q <= PAUSE;
                  end else if (bus.tick_in) begin
                     if (remaining_q > WIDTH'(1)) begin
                        remaining_q <= remaining_q - WIDTH'(1);
                     end else begin
                        expired_q <= 1'b1;
                        if (ar_q) begin
                           remaining_q <= reload_q;
                        end else begin
                           remaining_q <= '0;
                           state_q     <= IDLE;
                           busy_q      <= 1'b0;
                        end
                     end
                  end
               end
               PAUSE: begin
                  if (!bus.pause) state_q <= RUN;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.remaining = remaining_q;
   assign bus.expired   = expired_q;
   assign dbg_state_o   = state_q;

`ifdef TICK_TIMEOUT_EN
   localparam int GAP_LIMIT = 2 * TICK_GAP;
   localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_d;
   logic             fault_q;

   // Counts clk cycles spent in RUN since the last tick; saturates at the limit.
   always_comb begin
      gap_d = '0;
      if (state_q == RUN && !bus.tick_in && !bus.start) begin
         if (gap_q == GAP_W'(GAP_LIMIT)) gap_d = gap_q;
         else                            gap_d = gap_q + GAP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gap_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         gap_q <= gap_d;
         if (bus.start && !bus.stop)           fault_q <= 1'b0;
         else if (gap_d == GAP_W'(GAP_LIMIT))  fault_q <= 1'b1;
      end
   end

   assign bus.tick_fault = fault_q;
`else
   assign bus.tick_fault = 1'b0;
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: expected {busy, expired, remaining} words are
// queued as each step is driven and compared once the clk edge has passed.
module tb_tick_timer;
   localparam int W  = 16;
   localparam int EW = W + 2;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;

   tick_timer_if #(.WIDTH(W)) ifc ();

   tick_timer #(.WIDTH(W), .TICK_GAP(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (ifc.slave),
      .dbg_state_o (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [EW-1:0] exp_q[$];
   string         tag_q[$];
   logic          exp_fault;
   int            total;
   int            bad;

   task automatic push_exp(input string tag, input logic b, input logic e, input logic [W-1:0] r);
      exp_q.push_back({b, e, r});
      tag_q.push_back(tag);
   endtask

   task automatic check_out();
      logic [EW-1:0] got;
      logic [EW-1:0] exp;
      string         tag;
      got = {ifc.busy, ifc.expired, ifc.remaining};
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty got=%h", got);
      end else begin
         exp = exp_q.pop_front();
         tag = tag_q.pop_front();
         assert (got === exp) else begin
            bad++;
            $error("FAIL %s busy/exp/rem got=%h want=%h", tag, got, exp);
         end
         total++;
         assert (ifc.tick_fault === exp_fault) else begin
            bad++;
            $error("FAIL %s tick_fault got=%b want=%b", tag, ifc.tick_fault, exp_fault);
         end
      end
   endtask

   // One clk step: stimulus already applied, expectation queued, pulses cleared after.
   task automatic cyc(input string tag, input logic b, input logic e, input logic [W-1:0] r);
      push_exp(tag, b, e, r);
      @(posedge clk);
      #1;
      check_out();
      ifc.tick_in = 1'b0;
      ifc.start   = 1'b0;
      ifc.stop    = 1'b0;
   endtask

   task automatic idle(input int n, input string tag, input logic b, input logic [W-1:0] r);
      for (int i = 0; i < n; i++) cyc(tag, b, 1'b0, r);
   endtask

   task automatic do_start(input logic [W-1:0] lv, input logic ar);
      ifc.start       = 1'b1;
      ifc.load_val    = lv;
      ifc.auto_reload = ar;
   endtask

   initial begin
      logic [W-1:0] k;
      total = 0;
      bad   = 0;
      exp_fault       = 1'b0;
      ifc.tick_in     = 1'b0;
      ifc.load_val    = '0;
      ifc.start       = 1'b0;
      ifc.stop        = 1'b0;
      ifc.pause       = 1'b0;
      ifc.auto_reload = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      push_exp("reset_state", 1'b0, 1'b0, '0);
      check_out();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      idle(2, "idle_after_reset", 1'b0, '0);

      // basic countdown, one tick every 10 clks
      do_start(16'd3, 1'b0);
      cyc("basic_start", 1'b1, 1'b0, 16'd3);
      idle(9, "basic_wait3", 1'b1, 16'd3);
      ifc.tick_in = 1'b1;
      cyc("basic_t1", 1'b1, 1'b0, 16'd2);
      idle(9, "basic_wait2", 1'b1, 16'd2);
      ifc.tick_in = 1'b1;
      cyc("basic_t2", 1'b1, 1'b0, 16'd1);
      idle(9, "basic_wait1", 1'b1, 16'd1);
      ifc.tick_in = 1'b1;
      cyc("basic_expire", 1'b0, 1'b1, 16'd0);
      idle(3, "basic_done", 1'b0, '0);

      // auto-reload: expiry every second tick, busy held
      do_start(16'd2, 1'b1);
      cyc("ar_start", 1'b1, 1'b0, 16'd2);
      k = 16'd2;
      for (int i = 0; i < 6; i++) begin
         ifc.tick_in = 1'b1;
         if (k == 16'd2) begin
            k = 16'd1;
            cyc("ar_tick_dec", 1'b1, 1'b0, k);
         end else begin
            k = 16'd2;
            cyc("ar_tick_reload", 1'b1, 1'b1, k);
         end
         idle(2, "ar_gap", 1'b1, k);
      end
      ifc.stop = 1'b1;
      cyc("ar_stop", 1'b0, 1'b0, '0);

      // pause with ticks on the pause rise and fall edges
      do_start(16'd4, 1'b0);
      cyc("pause_start", 1'b1, 1'b0, 16'd4);
      ifc.tick_in = 1'b1;
      cyc("pause_t1", 1'b1, 1'b0, 16'd3);
      idle(2, "pause_run", 1'b1, 16'd3);
      ifc.pause = 1'b1;
      ifc.tick_in = 1'b1;
      cyc("pause_rise_tick", 1'b1, 1'b0, 16'd3);
      ifc.tick_in = 1'b1;
      cyc("pause_mid_tick", 1'b1, 1'b0, 16'd3);
      idle(2, "pause_hold", 1'b1, 16'd3);
      ifc.pause = 1'b0;
      ifc.tick_in = 1'b1;
      cyc("pause_fall_tick", 1'b1, 1'b0, 16'd3);
      ifc.tick_in = 1'b1;
      cyc("resume_t1", 1'b1, 1'b0, 16'd2);
      ifc.tick_in = 1'b1;
      cyc("resume_t2", 1'b1, 1'b0, 16'd1);
      ifc.tick_in = 1'b1;
      cyc("resume_expire", 1'b0, 1'b1, 16'd0);
      idle(1, "pause_done", 1'b0, '0);

      // priority, restart and zero-interval start
      do_start(16'd5, 1'b0);
      cyc("prio_start", 1'b1, 1'b0, 16'd5);
      ifc.tick_in = 1'b1;
      cyc("prio_tick", 1'b1, 1'b0, 16'd4);
      do_start(16'd9, 1'b0);
      ifc.stop = 1'b1;
      ifc.tick_in = 1'b1;
      cyc("prio_stop_wins", 1'b0, 1'b0, '0);
      idle(1, "prio_idle", 1'b0, '0);
      do_start(16'd0, 1'b0);
      cyc("zero_start_pulse", 1'b0, 1'b1, '0);
      idle(2, "zero_start_after", 1'b0, '0);
      do_start(16'd5, 1'b0);
      cyc("restart_a", 1'b1, 1'b0, 16'd5);
      ifc.tick_in = 1'b1;
      cyc("restart_tick", 1'b1, 1'b0, 16'd4);
      do_start(16'd7, 1'b0);
      ifc.tick_in = 1'b1;
      cyc("restart_b", 1'b1, 1'b0, 16'd7);
      ifc.stop = 1'b1;
      cyc("restart_stop", 1'b0, 1'b0, '0);
      ifc.stop = 1'b1;
      cyc("stop_in_idle", 1'b0, 1'b0, '0);

      // asynchronous reset between edges
      do_start(16'd100, 1'b0);
      cyc("rst_start", 1'b1, 1'b0, 16'd100);
      for (int i = 1; i <= 5; i++) begin
         ifc.tick_in = 1'b1;
         cyc("rst_tick", 1'b1, 1'b0, 16'(100 - i));
      end
      #2 reset = 1'b0;
      #1;
      push_exp("async_reset", 1'b0, 1'b0, '0);
      check_out();
      idle(1, "reset_held", 1'b0, '0);
      reset = 1'b1;
      idle(2, "reset_released", 1'b0, '0);

`ifdef TICK_TIMEOUT_EN
      // TICK_GAP=8: 16 RUN cycles without a tick raise the fault
      do_start(16'd10, 1'b0);
      cyc("to_start", 1'b1, 1'b0, 16'd10);
      idle(15, "to_no_fault", 1'b1, 16'd10);
      exp_fault = 1'b1;
      cyc("to_fault_set", 1'b1, 1'b0, 16'd10);
      ifc.tick_in = 1'b1;
      cyc("to_sticky_tick", 1'b1, 1'b0, 16'd9);
      idle(2, "to_sticky", 1'b1, 16'd9);
      do_start(16'd3, 1'b0);
      exp_fault = 1'b0;
      cyc("to_clear_start", 1'b1, 1'b0, 16'd3);
      ifc.stop = 1'b1;
      cyc("to_stop", 1'b0, 1'b0, '0);
`else
      // without the detector a long tickless RUN never flags a fault
      do_start(16'd10, 1'b0);
      cyc("nofault_start", 1'b1, 1'b0, 16'd10);
      idle(20, "nofault_wait", 1'b1, 16'd10);
      ifc.stop = 1'b1;
      cyc("nofault_stop", 1'b0, 1'b0, '0);
`endif

      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Programmable countdown timer; the consumer end of the 0.1 ms tick strobe produced by the design's tick generator.
- Counts tick strobes, not clk cycles. Gives game logic fixed game-time intervals such as spawn delays, invulnerability windows and round timers.
- Supports start, stop, pause and auto-reload. Emits a one-cycle expiry pulse.

Parameters:
- WIDTH, 16, width of load value and remaining count; max interval (2^WIDTH-1) ticks.
- TICK_GAP, 5000, nominal clk cycles between tick strobes; used only by the optional feature.

Ports:
- clk  in  1  system clock; only clock.
- reset  in  1  reset; one clock; reset is asynchronous and active-low.
- tick_in  in  1  one-cycle strobe from the tick generator, synchronous to clk.
- load_val  in  WIDTH  interval in ticks, sampled on start.
- start  in  1  one-cycle pulse: load and run.
- stop  in  1  one-cycle pulse: abort.
- pause  in  1  level: freeze count while high.
- auto_reload  in  1  level: sampled on start; if set, reload on expiry.
- busy  out  1  high in RUN or PAUSE.
- remaining  out  WIDTH  ticks left; registered.
- expired  out  1  one-cycle pulse on expiry.
- tick_fault  out  1  sticky missing-tick flag (optional feature only).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; remaining=0; busy=0; expired=0; tick_fault=0.
  - Internal reload register and auto-reload flag = 0.
- States: IDLE, RUN, PAUSE. busy = (state != IDLE), registered.
- Priority in any cycle: stop > start > tick_in.
- IDLE:
  - start with load_val != 0: remaining<=load_val, reload_reg<=load_val, ar_reg<=auto_reload, go RUN.
  - start with load_val == 0: expired=1 next cycle, stay IDLE, remaining stays 0.
- RUN:
  - tick_in=1 and pause=0: if remaining>1, remaining<=remaining-1.
  - tick_in=1 and pause=0 and remaining==1: expired=1 in the following cycle.
    - ar_reg=1: remaining<=reload_reg, stay RUN.
    - ar_reg=0: remaining<=0, go IDLE.
  - pause=1: go PAUSE. A tick_in in that same cycle is ignored.
- PAUSE:
  - tick_in ignored; remaining held.
  - pause=0: return to RUN. A tick_in in that cycle is ignored; counting resumes on the next cycle.
- stop (RUN or PAUSE): go IDLE, remaining<=0, no expired pulse. In IDLE, stop is a no-op.
- start while RUN or PAUSE: restart. New load_val, reload_reg and ar_reg are captured, state=RUN (pause must be low to count). Any tick in that cycle is ignored.
- Simultaneous start and stop: stop wins, result IDLE.
- Latency:
  - tick_in sampled at edge N gives the remaining update visible after edge N.
  - expired is high for exactly one cycle after the edge that consumed the final tick.
- No wrap-around: remaining never decrements below 1 in RUN and never underflows.
- Reset mid-run: immediate return to reset values; no expired pulse.

Optional Feature:
- Macro: TICK_TIMEOUT_EN.
- Defined:
  - A gap counter (width sufficient for 2*TICK_GAP) counts clk cycles while state=RUN.
  - It clears on tick_in, on entry to RUN, and whenever state is not RUN.
  - When the counter reaches 2*TICK_GAP, tick_fault<=1 (sticky).
  - tick_fault clears only on reset or start. The timer keeps running.
- Undefined: no gap counter; tick_fault tied to 0; TICK_GAP unused.

Test Plan:
- Basic countdown: reset released; start with load_val=3, auto_reload=0; tick_in every 10 clks -> remaining 3,2,1; expired single pulse after 3rd tick; busy falls the same cycle; remaining=0.
- Auto-reload: load_val=2, auto_reload=1; 6 ticks -> expired pulses after ticks 2, 4 and 6; remaining goes 2,1,2,1,2,1,2; busy stays 1.
- Pause and boundary: load_val=4; 1 tick; pause=1 for 3 ticks, including a tick coinciding with pause rise and one with pause fall -> remaining holds 3 throughout; after release, 3 more ticks -> expired.
- Priority: in RUN, drive start(load_val=9), stop and tick_in in the same cycle -> IDLE, remaining=0, no expired; start with load_val=0 -> one expired pulse, busy stays 0.
- Async reset mid-run: load_val=100, 5 ticks, then reset low between edges -> all outputs 0 immediately, without waiting for a clk edge.
- TICK_TIMEOUT_EN: TICK_GAP=8; RUN with no ticks for 16 clks -> tick_fault=1 and stays high through later ticks; next start -> tick_fault=0. Macro undefined -> tick_fault constant 0.
